freq_meter: RTL

Gated frequency counter: the measuring counterpart to the clock divider. It counts rising edges of an asynchronous or slow input over a fixed gate window of `GATE_CYCLES` system clocks. At the end of each window it publishes the count together with a one-cycle valid strobe. With the default 1 s gate at 100 MHz, `freq_out` reads directly in Hz; it sits beside the divider to check derived clocks and external tick sources.

---
 rtl/freq_meter_pkg.sv | 35 +++
 rtl/freq_meter_edge_sync.sv | 54 +++++
 rtl/freq_meter.sv | 74 +++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared defaults and the saturating adder used by freq_meter.
package freq_meter_pkg;

    localparam int unsigned FREQ_METER_GATE_DEFAULT  = 100000000;
    localparam int unsigned FREQ_METER_WIDTH_DEFAULT = 28;

    // Result of a saturating add: clipped sum plus a flag raised when an
    // increment had to be dropped because the value was already at all-ones.
    typedef struct packed {
        logic [63:0] sum;
        logic        sat;
    } sat_add_t;

    // Adds inc to a, clipping at the all-ones value of a width-bit counter.
    // Widths up to 63 bits are supported.
    function automatic sat_add_t sat_add(input logic [63:0] a,
                                         input logic inc,
                                         input int unsigned width);
        logic [63:0] max_val;
        sat_add_t    r;
        max_val = (64'd1 << width) - 64'd1;
        r.sum   = a;
        r.sat   = 1'b0;
        if (inc) begin
            if (a >= max_val) begin
                r.sum = max_val;
                r.sat = 1'b1;
            end else begin
                r.sum = a + 64'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// edge_sync: input register, previous-value register and rising-edge detect.
// With FREQ_METER_SYNC_EN defined, a two-flop synchronizer precedes sig_r.
// All flops reset to 1 so an input already high at reset is not an edge.
module edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise
);

    logic sig_r;
    logic prev;

`ifdef FREQ_METER_SYNC_EN
    logic sync_1;
    logic sync_2;

    // Two-flop synchronizer for an input asynchronous to clk.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= sig_in;
            sync_2 <= sync_1;
        end
    end

    // Register the synchronized input and keep its previous value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sig_r <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sig_r <= sync_2;
            prev  <= sig_r;
        end
    end
`else
    // Register the input directly and keep its previous value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sig_r <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sig_r <= sig_in;
            prev  <= sig_r;
        end
    end
`endif

    assign rise = sig_r & ~prev;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter. Counts rising edges of sig_in over a
// window of GATE_CYCLES clocks and publishes the count with a one-cycle
// freq_valid strobe. FREQ_METER_SYNC_EN adds an input synchronizer.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = FREQ_METER_GATE_DEFAULT,
    parameter int unsigned WIDTH_COUNT = FREQ_METER_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic                   sig_in,
    output logic [WIDTH_COUNT-1:0] freq_out,
    output logic                   freq_valid,
    output logic                   overflow
);

    localparam int unsigned       GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic [GATE_W-1:0]      gate_cnt;
    logic [WIDTH_COUNT-1:0] edge_cnt;
    logic                   sat;
    logic                   rise;
    sat_add_t               add_res;
    logic                   unused_sum_hi;

    edge_sync u_edge_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_in  (sig_in),
        .rise    (rise)
    );

    // Next edge count; the same value is the close value, so an edge in the
    // final gate cycle belongs to the closing window.
    always_comb begin
        add_res = sat_add(64'(edge_cnt), rise, WIDTH_COUNT);
    end

    assign unused_sum_hi = ^add_res.sum[63:WIDTH_COUNT];

    // Gate counter, edge counter and published result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            freq_out   <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (!en) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else if (gate_cnt == GATE_LAST) begin
                freq_out   <= add_res.sum[WIDTH_COUNT-1:0];
                overflow   <= sat | add_res.sat;
                freq_valid <= 1'b1;
                gate_cnt   <= '0;
                edge_cnt   <= '0;
                sat        <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt + GATE_W'(1);
                edge_cnt <= add_res.sum[WIDTH_COUNT-1:0];
                sat      <= sat | add_res.sat;
            end
        end
    end

endmodule
